// File: rtl/serial_adder.sv
// ----------------------------------------------------------------------------
// serial_adder
//   Bit-serial ripple adder. One full-adder step per clock, LSB first. WIDTH
//   steps produce the result. The sum, carry-out and signed overflow stay
//   registered until the next result is written.
//
// Ports
//   clk    in   1      rising-edge clock
//   rst    in   1      synchronous active-high reset; aborts any addition
//   start  in   1      begin an addition; accepted only while idle
//   A, B   in   WIDTH  operands, captured when start is accepted
//   Cin    in   1      carry-in, captured when start is accepted
//   busy   out  1      high while bits are being shifted through the adder
//   done   out  1      one-cycle pulse; S/Cout/V hold the new result
//   S      out  WIDTH  registered sum
//   Cout   out  1      registered carry-out of the MSB
//   V      out  1      registered signed overflow
// ----------------------------------------------------------------------------
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             V
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_d;
    logic             carry_q;
    logic             carry_d;
    logic             sum_bit;
    logic [CntW-1:0]  cnt_q;
    logic             last_bit;

    // Full-adder step on the current LSBs.
    always_comb begin
        sum_bit  = a_q[0] ^ b_q[0] ^ carry_q;
        carry_d  = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
        // Sum bits enter from the MSB side so after WIDTH steps bit 0 sits at the LSB.
        sum_d    = {sum_bit, sum_q[WIDTH-1:1]};
        last_bit = (cnt_q == CntW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            S       <= '0;
            Cout    <= 1'b0;
            V       <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q     <= A;
                        b_q     <= B;
                        carry_q <= Cin;
                        sum_q   <= '0;
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= StShift;
                    end
                end
                StShift: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    sum_q   <= sum_d;
                    carry_q <= carry_d;
                    cnt_q   <= cnt_q + 1'b1;
                    if (last_bit) begin
                        // carry_q is still the carry into the MSB on this edge.
                        S       <= sum_d;
                        Cout    <= carry_d;
                        V       <= carry_q ^ carry_d;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    done    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// ----------------------------------------------------------------------------
// tb_serial_adder
//   Directed bench for serial_adder at WIDTH=8 plus an exhaustive WIDTH=2
//   instance. Expected results are queued when an operation is accepted and
//   popped by per-instance monitors on each done pulse.
// ----------------------------------------------------------------------------
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    // WIDTH = 8 instance
    logic       start8, cin8, busy8, done8, cout8, v8;
    logic [7:0] a8, b8, s8;

    // WIDTH = 2 instance
    logic       start2, cin2, busy2, done2, cout2, v2;
    logic [1:0] a2, b2, s2;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .A     (a8),
        .B     (b8),
        .Cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .S     (s8),
        .Cout  (cout8),
        .V     (v8)
    );

    serial_adder #(.WIDTH(2)) u_dut2 (
        .clk   (clk),
        .rst   (rst),
        .start (start2),
        .A     (a2),
        .B     (b2),
        .Cin   (cin2),
        .busy  (busy2),
        .done  (done2),
        .S     (s2),
        .Cout  (cout2),
        .V     (v2)
    );

    int errors = 0;
    int checks = 0;

    // Expected {Cout, S, V}
    logic [9:0] q8[$];
    logic [3:0] q2[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitors
    always @(negedge clk) begin
        if (done8 === 1'b1) begin
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done8: got done=1, expected no pending result at %0t",
                         $time);
            end else begin
                check("result8", {22'd0, cout8, s8, v8}, {22'd0, q8.pop_front()});
            end
        end
    end

    always @(negedge clk) begin
        if (done2 === 1'b1) begin
            if (q2.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done2: got done=1, expected no pending result at %0t",
                         $time);
            end else begin
                check("result2", {28'd0, cout2, s2, v2}, {28'd0, q2.pop_front()});
            end
        end
    end

    // Present operands with start for one edge; also releases rst on that edge.
    task automatic accept8(input logic [7:0] a, input logic [7:0] b, input logic cin);
        a8     = a;
        b8     = b;
        cin8   = cin;
        start8 = 1'b1;
        rst    = 1'b0;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        check("accept_busy8", {30'd0, done8, busy8}, 32'b01);
    endtask

    // Run the remaining WIDTH edges while scrambling inputs and pulsing start
    // mid-shift and in DONE; neither may disturb the result or be queued.
    task automatic finish8();
        logic [9:0] prev;
        prev = {cout8, s8, v8};
        for (int i = 1; i <= 8; i++) begin
            start8 = (i == 3);
            a8     = 8'($urandom);
            b8     = 8'($urandom);
            cin8   = 1'($urandom);
            @(posedge clk);
            #1;
            if (i < 8) begin
                check("shift_state8", {30'd0, done8, busy8}, 32'b01);
                check("shift_hold8", {22'd0, cout8, s8, v8}, {22'd0, prev});
            end else begin
                check("done_state8", {30'd0, done8, busy8}, 32'b10);
            end
        end
        start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        check("done_to_idle8", {30'd0, done8, busy8}, 32'b00);
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic [7:0] es, input logic ec, input logic ev);
        accept8(a, b, cin);
        q8.push_back({ec, es, ev});
        finish8();
    endtask

    initial begin
        logic [4:0] nv;
        logic [2:0] t;
        logic       ev;

        rst    = 1'b1;
        start8 = 1'b0;
        a8     = 8'hA5;
        b8     = 8'h5A;
        cin8   = 1'b1;
        start2 = 1'b0;
        a2     = 2'b00;
        b2     = 2'b00;
        cin2   = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset8", {19'd0, busy8, done8, s8, cout8, v8}, 32'd0);
        check("reset2", {25'd0, busy2, done2, s2, cout2, v2}, 32'd0);

        // Start held with reset: reset wins, nothing accepted.
        start8 = 1'b1;
        @(posedge clk);
        #1;
        check("reset_priority8", {30'd0, done8, busy8}, 32'b00);
        start8 = 1'b0;
        rst    = 1'b0;
        @(posedge clk);
        #1;

        // Directed vectors: A, B, Cin -> S, Cout, V
        run8(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        run8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        run8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
        run8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
        run8(8'h3C, 8'h5A, 1'b1, 8'h97, 1'b0, 1'b1);
        run8(8'hC8, 8'h9C, 1'b0, 8'h64, 1'b1, 1'b1);
        run8(8'h0F, 8'hF0, 1'b1, 8'h00, 1'b1, 1'b0);
        run8(8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1);

        // Abort during SHIFT cycle 4: no result written, outputs cleared.
        accept8(8'hAA, 8'h55, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("pre_abort_busy8", {31'd0, busy8}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_clear8", {19'd0, busy8, done8, s8, cout8, v8}, 32'd0);
        // First edge with rst released and start high is accepted.
        accept8(8'h12, 8'h34, 1'b1);
        q8.push_back({1'b0, 8'h47, 1'b0});
        finish8();

        // WIDTH=2 exhaustive with start held high: accept every 4 cycles.
        for (int n = 0; n < 32; n++) begin
            nv     = 5'(n);
            a2     = nv[4:3];
            b2     = nv[2:1];
            cin2   = nv[0];
            start2 = 1'b1;
            t      = {1'b0, a2} + {1'b0, b2} + {2'b00, cin2};
            ev     = (a2[1] == b2[1]) && (t[1] != a2[1]);
            @(posedge clk);
            #1;
            check("accept_busy2", {30'd0, done2, busy2}, 32'b01);
            q2.push_back({t[2], t[1:0], ev});
            @(posedge clk);
            #1;
            check("shift_busy2", {30'd0, done2, busy2}, 32'b01);
            @(posedge clk);
            #1;
            check("done_state2", {30'd0, done2, busy2}, 32'b10);
            @(posedge clk);
            #1;
            check("idle_gap2", {30'd0, done2, busy2}, 32'b00);
        end
        start2 = 1'b0;

        repeat (12) @(posedge clk);
        #1;
        check("drain8", q8.size(), 32'd0);
        check("drain2", q2.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time bound in case the bench logic itself stalls.
    initial begin
        #200000;
        $display("FAIL timeout: got no completion, expected finish before 200000");
        $fatal(1);
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 Port: clk  input  1  rising-edge clock, sole clock.
REQ-004 Port: rst  input  1  synchronous active-high reset.
REQ-005 Port: start  input  1  request to begin an addition; sampled on rising clk edge.
REQ-006 Port: A  input  WIDTH  operand A; sampled only when start is accepted.
REQ-007 Port: B  input  WIDTH  operand B; sampled only when start is accepted.
REQ-008 Port: Cin  input  1  carry-in; sampled only when start is accepted.
REQ-009 Port: busy  output  1  high while an addition is in progress.
REQ-010 Port: done  output  1  one-cycle pulse; result outputs valid.
REQ-011 Port: S  output  WIDTH  registered sum.
REQ-012 Port: Cout  output  1  registered carry-out of the MSB.
REQ-013 Port: V  output  1  registered signed overflow (carry into MSB XOR Cout).

Function
REQ-014 Three states SHALL be implemented: IDLE, SHIFT, DONE.
REQ-015 IDLE: start=1 at an edge SHALL be accepted; A, B, Cin are loaded into internal shift/carry registers, the bit counter is cleared, and the state moves to SHIFT.
REQ-016 SHIFT: each edge SHALL run one full-adder step on the LSBs of the internal A/B registers and the carry register, shift the sum bit into the internal sum register from the MSB side, shift A/B right, update carry, and increment the counter.
REQ-017 SHIFT SHALL process exactly WIDTH bits LSB-first; the edge processing bit WIDTH-1 SHALL move the state to DONE.
REQ-018 That same edge SHALL write the internal sum to S, the final carry to Cout, and carry-into-MSB XOR final carry to V.
REQ-019 DONE SHALL last exactly one cycle, then return to IDLE unconditionally.
REQ-020 busy SHALL be 1 in SHIFT and 0 in IDLE and DONE.
REQ-021 done SHALL be 1 only in DONE.
REQ-022 Latency: with start accepted at edge E0, done SHALL be high in the cycle following edge E0+WIDTH.
REQ-023 S, Cout and V SHALL hold the last result from DONE until the next DONE; they SHALL NOT change during SHIFT.
REQ-024 start SHALL be ignored in SHIFT and DONE; no queuing.
REQ-025 Changes on A, B or Cin after acceptance SHALL NOT affect the running addition.
REQ-026 start held continuously high SHALL yield back-to-back operations every WIDTH+2 cycles.
REQ-027 Arithmetic is unsigned modulo 2^WIDTH for S; {Cout,S} SHALL equal A+B+Cin exactly.

Reset
REQ-028 rst=1 at an edge SHALL force IDLE, busy=0, done=0, S=0, Cout=0, V=0, and clear the internal registers and counter.
REQ-029 rst SHALL take priority over start and over any in-progress SHIFT (abort, no result written).
REQ-030 The first edge with rst=0 and start=1 SHALL be accepted normally.

Verification (WIDTH=8)
REQ-031 A=0x00,B=0x00,Cin=0 -> done pulse 8 cycles after acceptance, S=0x00, Cout=0, V=0.
REQ-032 A=0xFF,B=0x01,Cin=0 -> S=0x00, Cout=1, V=0; A=0x7F,B=0x01,Cin=0 -> S=0x80, Cout=0, V=1.
REQ-033 A=0xFF,B=0xFF,Cin=1 -> S=0xFF, Cout=1, V=0; A=0x80,B=0x80,Cin=0 -> S=0x00, Cout=1, V=1.
REQ-034 Start accepted, then A/B changed and start pulsed at SHIFT cycle 3 -> original result only, single done, busy unaffected.
REQ-035 rst asserted at SHIFT cycle 4 -> next cycle busy=0, done=0, S/Cout/V=0, no done pulse; subsequent start A=0x12,B=0x34,Cin=1 -> S=0x47, Cout=0.
REQ-036 WIDTH=2 exhaustive: all 32 A/B/Cin combinations -> {Cout,S}=A+B+Cin and V correct for each; done spacing WIDTH+2 with start held high.
